// File: rtl/riscv_pkg.sv
// Core-wide constants shared by pipeline-side helpers.
// Register file geometry and the hard-wired zero register.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/fwd_lookup.sv
// One forwarding lookup port over the writeback history.
// Youngest-first priority match; x0 never hits.
module fwd_lookup
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int REGW  = riscv_pkg::REGW,
  parameter int DEPTH = 2
) (
  input  logic [REGW-1:0]       addr,
  input  logic [XLEN-1:0]       dflt,
  input  logic [DEPTH-1:0]      vld,
  input  logic [DEPTH*REGW-1:0] rd,
  input  logic [DEPTH*XLEN-1:0] data,
  output logic                  hit,
  output logic [XLEN-1:0]       sel_data
);

  logic nonzero;

  assign nonzero = (addr != REGW'(REG_ZERO));

  // Walk oldest to youngest so the youngest match is the last writer.
  always_comb begin
    hit      = 1'b0;
    sel_data = dflt;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (nonzero && vld[i] && (rd[i*REGW +: REGW] == addr)) begin
        hit      = 1'b1;
        sel_data = data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/wb_forward_history.sv
// Writeback forwarding history: last DEPTH ALU results, NRP lookups.
// Stall holds, flush invalidates, hit counter saturates.
module wb_forward_history
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int REGW  = riscv_pkg::REGW,
  parameter int DEPTH = 2,
  parameter int NRP   = 2,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [REGW-1:0]      wr_rd,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [NRP*REGW-1:0]  lk_addr,
  input  logic [NRP*XLEN-1:0]  lk_dflt,
  output logic [NRP*XLEN-1:0]  lk_data,
  output logic [NRP-1:0]       lk_hit,
  output logic [CNTW-1:0]      hit_cnt
);

  logic [DEPTH-1:0]      vld;
  logic [REGW-1:0]       rd   [DEPTH];
  logic [XLEN-1:0]       data [DEPTH];
  logic [DEPTH*REGW-1:0] rd_vec;
  logic [DEPTH*XLEN-1:0] data_vec;
  logic                  push_vld;

  assign push_vld = wr_en && (wr_rd != REGW'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i]   <= '0;
        data[i] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0]  <= push_vld;
      rd[0]   <= wr_rd;
      data[0] <= wr_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        rd[i]   <= rd[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rd_vec[g*REGW +: REGW]   = rd[g];
    assign data_vec[g*XLEN +: XLEN] = data[g];
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_lookup #(
      .XLEN  (XLEN),
      .REGW  (REGW),
      .DEPTH (DEPTH)
    ) u_lookup (
      .addr     (lk_addr[p*REGW +: REGW]),
      .dflt     (lk_dflt[p*XLEN +: XLEN]),
      .vld      (vld),
      .rd       (rd_vec),
      .data     (data_vec),
      .hit      (lk_hit[p]),
      .sel_data (lk_data[p*XLEN +: XLEN])
    );
  end

  // Flush leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (!flush && !stall && (|lk_hit) && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_wb_forward_history.sv
// Directed bench for wb_forward_history.
// Default DUT plus DEPTH=1 and CNTW=4 variants on shared inputs.
module tb_wb_forward_history;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_rd = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  la0 = '0, la1 = '0;
  logic [31:0] df0 = '0, df1 = '0;
  logic [9:0]  lk_addr;
  logic [63:0] lk_dflt;
  logic [63:0] lk_data, lk_data1, lk_data4;
  logic [1:0]  lk_hit, lk_hit1, lk_hit4;
  logic [15:0] hit_cnt, hit_cnt1;
  logic [3:0]  hit_cnt4;
  logic [31:0] d0, d1;
  int n_run = 0;
  int n_fail = 0;

  assign lk_addr = {la1, la0};
  assign lk_dflt = {df1, df0};
  assign d0 = lk_data[31:0];
  assign d1 = lk_data[63:32];

  always #5 clk = ~clk;

  wb_forward_history dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .lk_addr(lk_addr), .lk_dflt(lk_dflt),
    .lk_data(lk_data), .lk_hit(lk_hit), .hit_cnt(hit_cnt)
  );

  wb_forward_history #(.DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .lk_addr(lk_addr), .lk_dflt(lk_dflt),
    .lk_data(lk_data1), .lk_hit(lk_hit1), .hit_cnt(hit_cnt1)
  );

  wb_forward_history #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .lk_addr(lk_addr), .lk_dflt(lk_dflt),
    .lk_data(lk_data4), .lk_hit(lk_hit4), .hit_cnt(hit_cnt4)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_en = 1'b1; wr_rd = r; wr_data = d;
    edge1();
    wr_en = 1'b0; wr_rd = '0; wr_data = '0;
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    df0 = 32'hD0D0_0000; df1 = 32'hD1D1_0000;
    la0 = 5'd5; la1 = 5'd6;
    #12;
    n_run++;
    if (lk_hit !== 2'b00) begin
      n_fail++; $display("FAIL reset_hit: got %b want 00", lk_hit);
    end
    n_run++;
    if (d0 !== 32'hD0D0_0000) begin
      n_fail++; $display("FAIL reset_data: got %h want d0d00000", d0);
    end
    n_run++;
    if (hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", hit_cnt);
    end
    rst = 1'b0;
    push(5'd5, 32'h55);
    push(5'd6, 32'h66);
    n_run++;
    if (lk_hit !== 2'b11 || hit_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL pre_reset: hit %b cnt %0d want 11 1", lk_hit, hit_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if (lk_hit !== 2'b00) begin
      n_fail++; $display("FAIL async_rst_hit: got %b want 00", lk_hit);
    end
    n_run++;
    if (d0 !== df0 || d1 !== df1) begin
      n_fail++; $display("FAIL async_rst_data: got %h %h want dflt", d0, d1);
    end
    n_run++;
    if (hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", hit_cnt);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_age_out();
    la0 = 5'd5; df0 = 32'h1234;
    la1 = 5'd0; df1 = 32'h0;
    push(5'd5, 32'hAAAA_0001);
    n_run++;
    if (lk_hit[0] !== 1'b1 || d0 !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL age_e1: hit %b data %h want 1 aaaa0001", lk_hit[0], d0);
    end
    n_run++;
    if (lk_hit1[0] !== 1'b1 || lk_data1[31:0] !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL age_d1_e1: hit %b data %h want 1 aaaa0001", lk_hit1[0], lk_data1[31:0]);
    end
    edge1();
    n_run++;
    if (lk_hit[0] !== 1'b1 || d0 !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL age_e2: hit %b data %h want 1 aaaa0001", lk_hit[0], d0);
    end
    n_run++;
    if (lk_hit1[0] !== 1'b0 || lk_data1[31:0] !== 32'h1234) begin
      n_fail++; $display("FAIL age_d1_e2: hit %b data %h want 0 1234", lk_hit1[0], lk_data1[31:0]);
    end
    edge1();
    n_run++;
    if (lk_hit[0] !== 1'b0 || d0 !== 32'h1234) begin
      n_fail++; $display("FAIL age_e3: hit %b data %h want 0 1234", lk_hit[0], d0);
    end
  endtask

  task automatic test_priority();
    la0 = 5'd7; la1 = 5'd7;
    df0 = 32'hEEEE; df1 = 32'hFFFF;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    n_run++;
    if (lk_hit !== 2'b11) begin
      n_fail++; $display("FAIL prio_hit: got %b want 11", lk_hit);
    end
    n_run++;
    if (d0 !== 32'h22 || d1 !== 32'h22) begin
      n_fail++; $display("FAIL prio_data: got %h %h want 22 22", d0, d1);
    end
    push(5'd8, 32'h88);
    n_run++;
    if (d0 !== 32'h22 || lk_hit !== 2'b11) begin
      n_fail++; $display("FAIL prio_older: data %h hit %b want 22 11", d0, lk_hit);
    end
  endtask

  task automatic test_x0();
    la0 = 5'd0; df0 = 32'hCAFE;
    la1 = 5'd0; df1 = 32'hBEEF;
    push(5'd0, 32'hFFFF_FFFF);
    n_run++;
    if (lk_hit !== 2'b00) begin
      n_fail++; $display("FAIL x0_hit: got %b want 00", lk_hit);
    end
    n_run++;
    if (d0 !== 32'hCAFE || d1 !== 32'hBEEF) begin
      n_fail++; $display("FAIL x0_data: got %h %h want cafe beef", d0, d1);
    end
  endtask

  task automatic test_stall_flush();
    rst_pulse();
    la0 = 5'd3; df0 = 32'hD000;
    la1 = 5'd4; df1 = 32'hD001;
    push(5'd3, 32'h33);
    stall = 1'b1;
    wr_en = 1'b1; wr_rd = 5'd4; wr_data = 32'h44;
    repeat (5) edge1();
    n_run++;
    if (lk_hit !== 2'b01) begin
      n_fail++; $display("FAIL stall_hit: got %b want 01", lk_hit);
    end
    n_run++;
    if (d0 !== 32'h33 || d1 !== 32'hD001) begin
      n_fail++; $display("FAIL stall_data: got %h %h want 33 d001", d0, d1);
    end
    n_run++;
    if (hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want 0", hit_cnt);
    end
    flush = 1'b1;
    edge1();
    flush = 1'b0; stall = 1'b0;
    wr_en = 1'b0; wr_rd = '0; wr_data = '0;
    n_run++;
    if (lk_hit !== 2'b00 || d0 !== 32'hD000) begin
      n_fail++; $display("FAIL flush_miss: hit %b data %h want 00 d000", lk_hit, d0);
    end
    n_run++;
    if (hit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_cnt: got %0d want 0", hit_cnt);
    end
    push(5'd3, 32'h35);
    edge1();
    n_run++;
    if (d0 !== 32'h35 || hit_cnt !== 16'd1) begin
      n_fail++; $display("FAIL post_flush: data %h cnt %0d want 35 1", d0, hit_cnt);
    end
  endtask

  task automatic test_counter();
    rst_pulse();
    la0 = 5'd9; la1 = 5'd0;
    wr_en = 1'b1; wr_rd = 5'd9; wr_data = 32'h99;
    for (int k = 1; k <= 20; k++) begin
      edge1();
      if (k == 10) begin
        n_run++;
        if (hit_cnt4 !== 4'd9 || hit_cnt !== 16'd9) begin
          n_fail++; $display("FAIL cnt_k10: got %0d %0d want 9 9", hit_cnt4, hit_cnt);
        end
      end
      if (k == 16) begin
        n_run++;
        if (hit_cnt4 !== 4'd15) begin
          n_fail++; $display("FAIL cnt_sat: got %0d want 15", hit_cnt4);
        end
      end
      if (k == 20) begin
        n_run++;
        if (hit_cnt4 !== 4'd15 || hit_cnt !== 16'd19) begin
          n_fail++; $display("FAIL cnt_nowrap: got %0d %0d want 15 19", hit_cnt4, hit_cnt);
        end
      end
    end
    wr_en = 1'b0; wr_rd = '0; wr_data = '0;
  endtask

  initial begin
    test_reset();
    test_age_out();
    test_priority();
    test_x0();
    test_stall_flush();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
